pci_bus_arbiter: RTL
====================

Name: pci_bus_arbiter

Overview:
- Central request/grant arbiter for the shared PCI-style bus.
- Sits directly upstream of the DMA controller and the 8085 bus interface: it receives each master's req and returns its gnt, for example the DMA's reqD/gntD pair.
- Grants one master at a time with round-robin fairness.
- Tracks bus ownership from FRAME#/IRDY# and revokes grants that are never used.

Parameters:
- NUM_MASTERS, 4, number of req/gnt pairs; index 0 is the highest priority after reset.
- START_TIMEOUT, 16, number of idle-bus cycles a granted master may wait before its grant is revoked.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > START_TIMEOUT.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_MASTERS  per-master bus request, active high.
- frame_n  in  1  bus FRAME#, active low.
- irdy_n  in  1  bus IRDY#, active low.
- gnt  out  NUM_MASTERS  per-master grant, registered; one-hot or all zero.
- owner  out  $clog2(NUM_MASTERS)  index of the currently/last granted master, registered.
- bus_idle  out  1  combinational, frame_n & irdy_n.
- timeout_err  out  1  registered one-cycle pulse when a grant is revoked for non-use.

Behaviour:
- Reset: synchronous, active high, overrides everything including mid-transaction. Next edge gives:
  - gnt=0, owner=0, timeout_err=0
  - state=IDLE, rr pointer ptr=0, cnt=0
- Round-robin pick: scan from ptr upward, wrapping at NUM_MASTERS-1 back to 0. The first set bit of the candidate vector wins.
- idle_q: registered copy of bus_idle.
- Transaction start: frame_n==0 && idle_q==1.
- timeout_err defaults to 0 every cycle. gnt never has more than one bit set.
- IDLE:
  - gnt=0.
  - If |req: w=pick(req); gnt<=onehot(w), owner<=w, cnt<=0, go to GRANTED. Latency is req to gnt in 1 cycle.
- GRANTED, conditions checked in priority order:
  - (a) Transaction start: go to ACTIVE, gnt held, ptr<=owner+1 mod N.
  - (b) req[owner]==0: gnt<=0, go to IDLE. Withdrawn request; ptr unchanged.
  - (c) bus_idle: cnt<=cnt+1. If cnt==START_TIMEOUT-1: gnt<=0, timeout_err<=1, ptr<=owner+1, go to IDLE.
  - (d) Otherwise hold. A busy bus does not advance cnt.
- ACTIVE, conditions checked in priority order:
  - (a) others = req & ~onehot(owner) is non-zero (hidden arbitration): w=pick(others); gnt<=onehot(w) (old gnt dropped in the same edge), owner<=w, cnt<=0, go to GRANTED. The current transaction finishes without gnt.
  - (b) bus_idle && req[owner]: go to GRANTED, gnt kept, cnt<=0.
  - (c) bus_idle && !req[owner]: gnt<=0, go to IDLE.
  - (d) Otherwise hold gnt.
- Simultaneous events:
  - A transaction start outranks req withdrawal on the same cycle; a master may drop req as it asserts FRAME#.
  - When a start and the timeout terminal count coincide, the start wins.
- Wrap: ptr and owner are computed mod NUM_MASTERS; when owner=N-1, ptr becomes 0.

Decomposition:
- Package pci_arb_pkg:
  - state enum IDLE=2'd0, GRANTED=2'd1, ACTIVE=2'd2
  - default NUM_MASTERS and START_TIMEOUT constants
  - onehot/index conversion functions
- Sub-module rr_priority_picker: combinational. Inputs are vec and ptr; outputs are valid and idx, and it performs the rotate-scan-unrotate.
- The top level holds the FSM, cnt, ptr, idle_q and the output registers.

Test Plan:
- Reset and single request: after reset, req=4'b0010. Required: gnt=4'b0010 one cycle later, owner=1. With frame_n pulled low after an idle cycle, state is ACTIVE and ptr=2. With frame_n and irdy_n high and req low, gnt=0 on the next cycle.
- Round-robin order: all req=4'b1111, each master runs a 3-cycle transaction then releases. Required: grant order 0,1,2,3,0; owner wraps 3 to 0.
- Timeout: req=4'b0100, bus idle, frame_n never asserted. Required: gnt=4'b0100 for exactly 16 idle cycles, then gnt=0 with timeout_err high for 1 cycle. Next round-robin pick starts at index 3.
- Hidden arbitration: master 0 is ACTIVE with frame_n low, and req[2] rises. Required: next edge gives gnt=4'b0100 and owner=2 while frame_n stays low. The master 2 timeout counter does not advance until bus_idle.
- Withdrawal versus start: in GRANTED, req[owner] falls on the same cycle frame_n falls after an idle cycle. Required: go to ACTIVE with gnt held. The withdrawal alone, with bus idle, gives gnt=0 and IDLE, with no timeout_err.
- Reset mid-transaction: assert reset while ACTIVE with gnt=4'b1000. Required: next edge gives gnt=0, owner=0, timeout_err=0. Subsequent req=4'b1001 grants master 0.

Source files
------------

// File: rtl/pci_arb_pkg.sv
// Shared types and helpers for the PCI bus arbiter: FSM encoding, default
// sizing and index/one-hot conversion.
package pci_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    ACTIVE  = 2'd2
  } arb_state_t;

  localparam int DEF_NUM_MASTERS   = 4;
  localparam int DEF_START_TIMEOUT = 16;
  localparam int MAX_MASTERS       = 32;

  function automatic logic [MAX_MASTERS-1:0] idx2oh(input int unsigned idx);
    return MAX_MASTERS'(1) << idx;
  endfunction

  function automatic int unsigned oh2idx(input logic [MAX_MASTERS-1:0] oh);
    int unsigned r;
    r = 0;
    for (int i = 0; i < MAX_MASTERS; i++)
      if (oh[i]) r = i;
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin pick: rotate vec so ptr lands at bit 0, take the lowest set
// bit, then rotate the winning offset back into an absolute index.
module rr_priority_picker #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;

  always_comb begin
    dbl   = {vec, vec} >> ptr;
    rot   = dbl[N-1:0];
    valid = 1'b0;
    off   = '0;
    // descending scan so the lowest set offset is the last one written
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[IW'(i)]) begin
        valid = 1'b1;
        off   = IW'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
    idx = sum[IW-1:0];
  end

endmodule

// File: rtl/pci_bus_arbiter.sv
// Round-robin req/gnt arbiter for the shared bus; follows FRAME#/IRDY# to
// track ownership, supports hidden arbitration and revokes unused grants.
module pci_bus_arbiter
  import pci_arb_pkg::*;
#(
  parameter  int NUM_MASTERS   = DEF_NUM_MASTERS,
  parameter  int START_TIMEOUT = DEF_START_TIMEOUT,
  parameter  int CNT_W         = 5,
  localparam int IDX_W         = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   frame_n,
  input  logic                   irdy_n,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [IDX_W-1:0]       owner,
  output logic                   bus_idle,
  output logic                   timeout_err
);

  arb_state_t             state, state_d;
  logic [IDX_W-1:0]       ptr, ptr_d, owner_d, owner_inc;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic [NUM_MASTERS-1:0] gnt_d, others;
  logic                   terr_d, idle_q, txn_start, req_own, tc;
  logic                   req_vld, oth_vld;
  logic [IDX_W-1:0]       req_idx, oth_idx;

  assign bus_idle  = frame_n & irdy_n;
  assign txn_start = !frame_n && idle_q;
  assign req_own   = req[owner];
  assign tc        = (cnt == CNT_W'(START_TIMEOUT - 1));
  assign owner_inc = (owner == IDX_W'(NUM_MASTERS - 1)) ? '0 : owner + IDX_W'(1);
  assign others    = req & ~NUM_MASTERS'(idx2oh(32'(owner)));

  rr_priority_picker #(.N(NUM_MASTERS)) u_pick_req (
    .vec(req), .ptr(ptr), .valid(req_vld), .idx(req_idx)
  );

  rr_priority_picker #(.N(NUM_MASTERS)) u_pick_oth (
    .vec(others), .ptr(ptr), .valid(oth_vld), .idx(oth_idx)
  );

  always_ff @(posedge clk) begin
    idle_q <= bus_idle;
    if (reset) begin
      state       <= IDLE;
      gnt         <= '0;
      owner       <= '0;
      ptr         <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      gnt         <= gnt_d;
      owner       <= owner_d;
      ptr         <= ptr_d;
      cnt         <= cnt_d;
      timeout_err <= terr_d;
    end
  end

  // a transaction start outranks both withdrawal and the timeout terminal count
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (|req) state_d = GRANTED;
      GRANTED: begin
        if (txn_start)            state_d = ACTIVE;
        else if (!req_own)        state_d = IDLE;
        else if (bus_idle && tc)  state_d = IDLE;
      end
      ACTIVE: begin
        if (oth_vld)              state_d = GRANTED;
        else if (bus_idle)        state_d = req_own ? GRANTED : IDLE;
      end
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d   = gnt;
    owner_d = owner;
    cnt_d   = cnt;
    ptr_d   = ptr;
    terr_d  = 1'b0;
    case (state)
      IDLE: begin
        gnt_d = '0;
        if (req_vld) begin
          gnt_d   = NUM_MASTERS'(idx2oh(32'(req_idx)));
          owner_d = req_idx;
          cnt_d   = '0;
        end
      end
      GRANTED: begin
        if (txn_start) begin
          ptr_d = owner_inc;
        end else if (!req_own) begin
          gnt_d = '0;
        end else if (bus_idle) begin
          cnt_d = cnt + CNT_W'(1);
          if (tc) begin
            gnt_d  = '0;
            terr_d = 1'b1;
            ptr_d  = owner_inc;
          end
        end
      end
      ACTIVE: begin
        if (oth_vld) begin
          gnt_d   = NUM_MASTERS'(idx2oh(32'(oth_idx)));
          owner_d = oth_idx;
          cnt_d   = '0;
        end else if (bus_idle) begin
          if (req_own) cnt_d = '0;
          else         gnt_d = '0;
        end
      end
      default: gnt_d = '0;
    endcase
  end

endmodule
